serial_detect_sched: RTL and testbench
======================================

# serial_detect_sched

Round-robin scheduler that shares one serial Moore-style sequence detector between `N_REQ` requesters. It grants one requester at a time and latches that requester's `WIDTH`-bit word. It then clears the detector and shifts the word in MSB first, one bit per clock, and counts the cycles on which the detector output is high. When the word is fully shifted, it returns the hit count to the granted requester with a one-cycle `done` pulse. It sits between the requester ports and the detector instance.

## Interface
- `N_REQ`, 4: number of requesters; 2..8.
- `WIDTH`, 8: bits per job; 2..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: per-requester request; held high until `done` for that requester.
- `data` in `N_REQ*WIDTH`: flattened words; requester i occupies `[i*WIDTH +: WIDTH]`.
- `gnt` out `N_REQ`: one-hot grant, high from grant through the DONE cycle.
- `busy` out 1: high in any state other than IDLE.
- `det_clr` out 1: active-high synchronous clear to the detector.
- `det_in` out 1: serial bit to the detector.
- `det_out` in 1: detector Moore output, registered inside the detector.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 3: index of the completed requester; valid with `done`, held afterwards.
- `hit_cnt` out 4: detector hits for the completed job; saturates at 15; held until the next `done`.

## Operation
- FSM states and transitions:
  - IDLE → CLEAR when `req` is nonzero.
  - CLEAR → SHIFT after 1 cycle.
  - SHIFT → FLUSH after `WIDTH` cycles.
  - FLUSH → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- IDLE:
  - Arbitrate round-robin.
  - Search starts at the index after the last granted requester; it starts at 0 after reset.
  - Winner: set `gnt`, latch its word into the shift register, clear the counter.
- CLEAR: `det_clr`=1 for one cycle; `det_in`=0.
- SHIFT:
  - `det_in` = shift register MSB; shift left each cycle.
  - A bit counter runs 0..`WIDTH`-1.
- Sampling of `det_out`:
  - Sampled on SHIFT cycles 1..`WIDTH`-1 and on FLUSH. That is `WIDTH` samples, one after each shifted bit.
  - SHIFT cycle 0 is not sampled (detector still in its cleared state).
  - Each sample with `det_out`=1 increments the counter; it saturates at 4'hF.
- DONE: `done`=1; `done_id` and `hit_cnt` update; `gnt` is still high this cycle.
- A requester dropping `req` mid-job does not abort the job; it completes normally.
- `data` is sampled only at grant; later changes are ignored.
- There is no back-to-back grant: one IDLE cycle always separates jobs.
- Simultaneous requests resolve by round-robin order only.
- Reset values, all outputs 0: `gnt`, `busy`, `det_clr`, `det_in`, `done`, `done_id`, `hit_cnt`. State = IDLE; round-robin pointer = 0.
- Reset mid-job: immediate return to IDLE, no `done`, counter discarded.

## Timing
- With `req` sampled high in IDLE at edge 0:
  - `gnt`/CLEAR from edge 0.
  - SHIFT at edges 1..`WIDTH`.
  - FLUSH at edge `WIDTH`+1.
  - `done` at edge `WIDTH`+2; 10 cycles for `WIDTH`=8.
- Job period is `WIDTH`+4 cycles including the IDLE cycle; 12 for `WIDTH`=8.
- Detector contract: `det_out` is valid the cycle after the edge that consumed `det_in` (Moore, one-cycle lag).

## Configuration
- `SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority; the lowest asserted `req` index wins every arbitration, and the round-robin pointer is removed.
  - Undefined (default): round-robin as above.

## Test plan
Bench detector model: overlapping "11" detector, output 1 when the last two bits are both 1, cleared by `det_clr`.
- Reset low mid-SHIFT, then release → all outputs 0 within the same cycle; no `done`; the next job runs normally.
- `req`=4'b0001, word 8'hFF → `done` 10 cycles after grant; `done_id`=0; `hit_cnt`=7.
- `req`=4'b0100, word 8'hF0 → `hit_cnt`=3, `done_id`=2.
- Word 8'hAA and word 8'h00 → `hit_cnt`=0 for both; `det_clr` pulses exactly once per job.
- `req`=4'b1111 held from reset:
  - Without the macro: grant order 0,1,2,3,0, with a period of 12 cycles.
  - With `SCHED_FIXED_PRIO_EN`: grants stay on 0.
- `req[1]` dropped during SHIFT → job still completes with `done_id`=1; `data[1]` changed mid-job does not affect `hit_cnt`.

Source files
------------

// File: rtl/serial_detect_sched.sv
// serial_detect_sched: shares one serial Moore sequence detector between
// N_REQ requesters. It grants one requester, shifts that requester's word
// into the detector MSB first, counts the detector hits and returns the
// count with a one-cycle done pulse.
// Build option: SCHED_FIXED_PRIO_EN selects fixed priority, where the lowest
// index wins. When it is undefined, arbitration is round-robin.
//
// state  | meaning
// IDLE   | arbitrate; latch the winner's word
// CLEAR  | det_clr pulse, detector reset
// SHIFT  | WIDTH cycles, det_in = word MSB, sample det_out from cycle 1
// FLUSH  | take the last sample, for the final shifted bit
// DONE   | done pulse; done_id / hit_cnt valid
module serial_detect_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     det_clr,
  output logic                     det_in,
  input  logic                     det_out,
  output logic                     done,
  output logic [2:0]               done_id,
  output logic [3:0]               hit_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_q;
  logic [3:0]        bit_cnt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [2:0]        cur_id;
  logic [7:0]        req_pad;
  logic [3:0]        base;
  logic [3:0]        cand;
  logic              win_vld;
  logic [2:0]        win_idx;
  logic [WIDTH-1:0]  win_word;
`ifndef SCHED_FIXED_PRIO_EN
  logic [2:0]        rr_ptr;
`endif

  // Arbiter: walk the requests starting at the search base and pick the first one asserted.
  always_comb begin
    req_pad = '0;
    req_pad[N_REQ-1:0] = req;
`ifdef SCHED_FIXED_PRIO_EN
    base = 4'd0;
`else
    base = {1'b0, rr_ptr};
`endif
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = base + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!win_vld && req_pad[cand[2:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[2:0];
      end
    end
    win_word = WIDTH'(data >> (int'(win_idx) * WIDTH));
  end

  // Saturating increment of the hit counter for the current detector sample.
  always_comb begin
    cnt_nx = cnt;
    if (det_out && cnt != 4'hF) cnt_nx = cnt + 4'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and the outputs decoded from the state.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    det_clr = 1'b0;
    det_in  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (win_vld) state_d = S_CLEAR;
      S_CLEAR: begin
        det_clr = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        det_in = sh_q[WIDTH-1];
        if (bit_cnt == 4'(WIDTH-1)) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: grant capture, shift register, bit and hit counters, result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt     <= '0;
      sh_q    <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      cur_id  <= '0;
      done_id <= '0;
      hit_cnt <= '0;
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt     <= N_REQ'(1) << win_idx;
            sh_q    <= win_word;
            bit_cnt <= '0;
            cnt     <= '0;
            cur_id  <= win_idx;
`ifndef SCHED_FIXED_PRIO_EN
            rr_ptr  <= (win_idx == 3'(N_REQ-1)) ? 3'd0 : win_idx + 3'd1;
`endif
          end
        end
        S_SHIFT: begin
          sh_q    <= sh_q << 1;
          bit_cnt <= bit_cnt + 4'd1;
          // Cycle 0 sees the detector still cleared, so it is not sampled.
          if (bit_cnt != 4'd0) cnt <= cnt_nx;
        end
        S_FLUSH: begin
          cnt     <= cnt_nx;
          hit_cnt <= cnt_nx;
          done_id <= cur_id;
        end
        S_DONE: gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_detect_sched.sv
// Directed bench for serial_detect_sched. It models an overlapping "11"
// detector and checks the results with immediate assertions.
module tb_serial_detect_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        busy, det_clr, det_in, det_out, done;
  logic [2:0]  done_id;
  logic [3:0]  hit_cnt;

  logic        det_prev;
  int          total, bad;
  int          clr_cnt, done_cnt, cyc;

  serial_detect_sched #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .det_clr(det_clr), .det_in(det_in), .det_out(det_out), .done(done),
    .done_id(done_id), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model: registered output, high when the last two bits consumed were both 1.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_prev <= 1'b0;
      det_out  <= 1'b0;
    end else if (det_clr) begin
      det_prev <= 1'b0;
      det_out  <= 1'b0;
    end else begin
      det_prev <= det_in;
      det_out  <= det_prev & det_in;
    end
  end

  // Event counters used by the checks.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (det_clr) clr_cnt <= clr_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [3:0] r, input logic [2:0] exp_id,
                         input logic [3:0] exp_hit, input bit drop_mid);
    int n;
    req = r;
    clr_cnt = 0;
    n = 0;
    while (gnt == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".gnt"}, 32'(gnt), 32'(r));
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
      if (drop_mid && n == 4) begin
        req = 4'd0;
        data[15:8] = 8'h00;
      end
    end
    check({tag, ".latency"}, 32'(n), 32'd10);
    check({tag, ".done_id"}, 32'(done_id), 32'(exp_id));
    check({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
    check({tag, ".gnt_in_done"}, 32'(gnt), 32'(r));
    check({tag, ".clr_pulses"}, 32'(clr_cnt), 32'd1);
    req = 4'd0;
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".gnt_release"}, 32'(gnt), 32'd0);
    check({tag, ".hit_hold"}, 32'(hit_cnt), 32'(exp_hit));
  endtask

  initial begin
    int n;
    int last_cyc;
    logic [3:0] exp_g;
    total = 0; bad = 0; clr_cnt = 0; done_cnt = 0; cyc = 0;
    reset = 1'b0; req = 4'd0; data = 32'd0;
    repeat (2) @(negedge clk);
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.det_clr", 32'(det_clr), 32'd0);
    check("rst.det_in", 32'(det_in), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.done_id", 32'(done_id), 32'd0);
    check("rst.hit_cnt", 32'(hit_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    data[7:0] = 8'hFF;
    run_job("ff", 4'b0001, 3'd0, 4'd7, 1'b0);
    data[23:16] = 8'hF0;
    run_job("f0", 4'b0100, 3'd2, 4'd3, 1'b0);
    data[7:0] = 8'hAA;
    run_job("aa", 4'b0001, 3'd0, 4'd0, 1'b0);
    data[31:24] = 8'h00;
    run_job("zero", 4'b1000, 3'd3, 4'd0, 1'b0);
    data[15:8] = 8'hFF;
    run_job("drop", 4'b0010, 3'd1, 4'd7, 1'b1);

    // Reset in the middle of SHIFT.
    data[7:0] = 8'hFF;
    req = 4'b0001;
    n = 0;
    while (gnt == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("midrst.det_in_before", 32'(det_in), 32'd1);
    done_cnt = 0;
    #2 reset = 1'b0;
    #1;
    check("midrst.gnt", 32'(gnt), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.det_in", 32'(det_in), 32'd0);
    check("midrst.done_id", 32'(done_id), 32'd0);
    check("midrst.hit_cnt", 32'(hit_cnt), 32'd0);
    req = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst.no_done", 32'(done_cnt), 32'd0);
    check("midrst.idle", 32'(busy), 32'd0);
    data[23:16] = 8'hF0;
    run_job("after_rst", 4'b0100, 3'd2, 4'd3, 1'b0);

    // All four requesters held from reset.
    reset = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 4'd0 && n < 30) begin
        @(negedge clk);
        n++;
      end
`ifdef SCHED_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      check($sformatf("rr.gnt%0d", k), 32'(gnt), 32'(exp_g));
      if (k > 0) check($sformatf("rr.period%0d", k), 32'(cyc - last_cyc), 32'd12);
      last_cyc = cyc;
      n = 0;
      while (gnt != 4'd0 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    req = 4'd0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
